// File: rtl/rv32_fetch_stage.sv
// RV32 instruction fetch stage: PC, 2-slot in-order fetch queue and IF/ID register.
// Stale responses left in flight by a redirect are counted in drop_cnt and discarded.
module rv32_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc;
  logic [31:0] slot_pc    [2];
  logic [31:0] slot_instr [2];
  logic [1:0]  slot_filled;
  logic        head;
  logic        tail;
  logic [1:0]  used;
  logic [1:0]  drop_cnt;

  logic        req_fire;
  logic        head_unfilled;
  logic        second_unfilled;
  logic [1:0]  unfilled_cnt;
  logic        rsp_fill;
  logic        rsp_drop;
  logic        fill_idx;
  logic        head_ready;
  logic        head_bypass;
  logic        load_en;
  logic        pop;
  logic [1:0]  drop_next;
  logic [1:0]  unused_redirect_lo;

  assign unused_redirect_lo = redirect_pc[1:0];

  // Stale responses still owe the memory a slot, so they count against the in-flight cap.
  assign imem_req_valid = rst_n && !redirect_valid &&
                          (({1'b0, used} + {1'b0, drop_cnt}) < 3'd2);
  assign imem_req_addr  = pc;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    req_fire        = imem_req_valid && imem_req_ready;
    head_unfilled   = (used != 2'd0) && !slot_filled[head];
    second_unfilled = (used == 2'd2) && slot_filled[head] && !slot_filled[~head];
    unfilled_cnt    = 2'd0;
    if (head_unfilled) unfilled_cnt = unfilled_cnt + 2'd1;
    if ((used == 2'd2) && !slot_filled[~head]) unfilled_cnt = unfilled_cnt + 2'd1;

    rsp_fill    = imem_rsp_valid && (drop_cnt == 2'd0) && (head_unfilled || second_unfilled);
    fill_idx    = head_unfilled ? head : ~head;
    head_ready  = (used != 2'd0) && slot_filled[head];
    head_bypass = rsp_fill && head_unfilled;
    load_en     = !stall || !if_id_valid;
    pop         = !redirect_valid && load_en && (head_ready || head_bypass);

    // On a redirect, a response aimed at a now-stale slot is dropped here instead of filling.
    rsp_drop  = imem_rsp_valid &&
                ((drop_cnt != 2'd0) || (redirect_valid && (unfilled_cnt != 2'd0)));
    drop_next = drop_cnt + (redirect_valid ? unfilled_cnt : 2'd0) - {1'b0, rsp_drop};
  end

  // NOTE: slot payload is not reset; slot_filled and used qualify every read of it.
  always_ff @(posedge clk) begin
    if (req_fire) slot_pc[tail]        <= pc;
    if (rsp_fill) slot_instr[fill_idx] <= imem_rsp_data;
  end

  // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      slot_filled <= 2'b00;
      head        <= 1'b0;
      tail        <= 1'b0;
      used        <= 2'd0;
      drop_cnt    <= 2'd0;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc    <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      slot_filled <= 2'b00;
      head        <= 1'b0;
      tail        <= 1'b0;
      used        <= 2'd0;
      drop_cnt    <= drop_next;
      if_id_valid <= 1'b0;
    end else begin
      if (rsp_fill) slot_filled[fill_idx] <= 1'b1;
      if (req_fire) begin
        slot_filled[tail] <= 1'b0;
        tail              <= ~tail;
        pc                <= pc + 32'd4;
      end
      if (pop) head <= ~head;
      used     <= used + {1'b0, req_fire} - {1'b0, pop};
      drop_cnt <= drop_next;

      if (load_en) begin
        if (head_ready) begin
          if_id_valid <= 1'b1;
          if_id_instr <= slot_instr[head];
          if_id_pc    <= slot_pc[head];
        end else if (head_bypass) begin
          if_id_valid <= 1'b1;
          if_id_instr <= imem_rsp_data;
          if_id_pc    <= slot_pc[head];
        end else begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/rv32_fetch_stage.md
# rv32_fetch_stage

Instruction fetch (IF) stage of the RV32 five-stage pipeline.
- Holds the program counter and issues in-order word requests to instruction memory through a valid/ready request channel.
- Tracks up to two in-flight fetches in a 2-slot in-order queue.
- Fills the IF/ID pipeline register (instruction, pc) that feeds the decode stage.
- Honours decode back-pressure (stall) and branch/jump redirects from the execute stage, discarding stale responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  word address of the request (bits [1:0] always 0).
- imem_rsp_valid  in  1  response valid; in order, ≥1 cycle after acceptance, cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  EX-stage branch/jump taken.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0).
- stall  in  1  decode cannot accept; IF/ID must hold.
- if_id_valid  out  1  IF/ID register holds a live instruction.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc  out  32  address of if_id_instr.

## Operation
State:
- pc (next fetch address).
- 2-slot queue, each slot {pc, instr, filled}, with head/tail pointers and a used count 0..2.
- drop_cnt 0..2.

Reset:
- pc=RESET_PC; queue empty; drop_cnt=0.
- if_id_valid=0, if_id_instr=32'h0000_0013 (NOP), if_id_pc=0.
- imem_req_valid=0 while rst_n=0.

Request issue:
- imem_req_valid = !redirect_valid && (used + drop_cnt < 2). This caps requests in flight at memory at 2.
- imem_req_addr = pc.
- On accept (valid && ready): allocate tail slot {pc, unfilled}; pc <= pc+4, wrapping modulo 2^32.
- valid may drop before ready only because of a redirect.

Response:
- If drop_cnt>0: discard the response and decrement drop_cnt.
- Otherwise: write data into the oldest unfilled slot.
- A response with no unfilled slot and drop_cnt=0 is a protocol error; it is ignored.

IF/ID load, when !stall or !if_id_valid:
- Head slot filled: load {instr, pc} from it, set valid, pop the slot.
- Head slot being filled this cycle: bypass imem_rsp_data directly, set valid, pop.
- Otherwise, if !stall: if_id_valid <= 0.
- When stall && if_id_valid: the register holds and the queue keeps filling.

Redirect (highest priority):
- pc <= {redirect_pc[31:2], 2'b00}; queue cleared.
- if_id_valid <= 0, regardless of stall.
- drop_cnt <= drop_cnt + (number of allocated-unfilled slots) − (1 if a response arrives this cycle and targets those). In other words, a response arriving in the redirect cycle is discarded and counts against the stale total.
- No request issued in the redirect cycle.
- Allocation, fill and pop in the same cycle are all applied simultaneously; used is updated by their net effect.

## Timing
Zero-wait memory (ready=1, response 1 cycle after accept):
- Request accepted in cycle N; response in N+1; if_id_valid=1 in N+2.
- Sustained throughput is 1 instruction/cycle (bypass frees the slot in the fill cycle).
- First request is asserted in the first cycle after rst_n rises, with addr=RESET_PC.

Redirect in cycle R:
- Request at redirect_pc in R+1 if drop_cnt+used permits, else once stale responses drain.
- First redirected instruction visible at R+3 at the earliest.

Other:
- Stall held k cycles: IF/ID unchanged for k cycles; at most 2 queued instructions, then requests stop.
- Async reset mid-operation: all state returns to reset values immediately; responses after reset release for pre-reset requests are not supported (memory is reset together).

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr as data → addresses 0,4,8,… one per cycle; if_id_pc/instr 0,4,8 from cycle 2; no bubbles.
- Stall for 5 cycles during streaming → IF/ID frozen at pc 0x8; exactly 2 further requests (0xC, 0x10) issued, then req_valid=0; after release, 0xC, 0x10, 0x14 are consecutive.
- Redirect to 0x100 with 2 fetches in flight (3-cycle memory latency) → drop_cnt=2; next 2 responses discarded; first if_id_pc after redirect is 0x100, never 0x8 or 0xC.
- Redirect coincident with a response and with stall=1 → response dropped, if_id_valid=0 next cycle, next request addr 0x100.
- imem_req_ready=0 for 4 cycles → addr held stable at 0x10; pc not advanced; no slot allocated.
- Redirect to 0xFFFF_FFFE, then stream → addresses 0xFFFF_FFFC, 0x0000_0000, 0x4 (alignment and wrap).
